// File: rtl/johnson_step_scheduler.sv
// Round-robin scheduler sharing one Johnson ring between two requesters; bursts step once per cycle.
// Accept in IDLE, N steps in RUN, then a one-cycle done pulse in DONE before returning to IDLE.
module johnson_step_scheduler #(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  input  logic [STEP_W-1:0]    req_steps_0,
  input  logic [STEP_W-1:0]    req_steps_1,
  output logic [1:0]           req_ready,
  input  logic                 abort,
  output logic                 jc_enable,
  output logic [WIDTH-1:0]     count,
  output logic [2*WIDTH-1:0]   phase,
  output logic                 owner,
  output logic                 busy,
  output logic [1:0]           done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    count_q, count_d;
  logic                owner_q, owner_d;
  logic [STEP_W-1:0]   remaining_q, remaining_d;

  logic                gnt;
  logic [STEP_W-1:0]   gnt_steps;
  logic                jc_en_raw;
  logic [1:0]          ready_raw;
  logic [1:0]          done_raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      owner_q     <= 1'b1;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      owner_q     <= owner_d;
      remaining_q <= remaining_d;
    end
  end

  // Contention goes to the requester that was not served last.
  always_comb begin
    gnt = 1'b0;
    if (req_valid == 2'b11) begin
      gnt = ~owner_q;
    end else if (req_valid[0]) begin
      gnt = 1'b0;
    end else begin
      gnt = 1'b1;
    end
    gnt_steps = gnt ? req_steps_1 : req_steps_0;
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    owner_d     = owner_q;
    remaining_d = remaining_q;
    jc_en_raw   = 1'b0;
    ready_raw   = 2'b00;
    done_raw    = 2'b00;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          ready_raw   = gnt ? 2'b10 : 2'b01;
          owner_d     = gnt;
          remaining_d = gnt_steps;
          state_d     = (gnt_steps != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (abort) begin
          remaining_d = '0;
          state_d     = DONE;
        end else begin
          jc_en_raw   = 1'b1;
          count_d     = {count_q[WIDTH-2:0], ~count_q[WIDTH-1]};
          // RUN is only entered with remaining >= 1, so this never wraps.
          remaining_d = (remaining_q != '0) ? remaining_q - STEP_W'(1) : '0;
          if (remaining_q <= STEP_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        done_raw = owner_q ? 2'b10 : 2'b01;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    int pc;
    int k;
    pc = 0;
    for (int i = 0; i < WIDTH; i++) begin
      pc = pc + int'(count_q[i]);
    end
    k = count_q[WIDTH-1] ? (2 * WIDTH - pc) : pc;
    for (int i = 0; i < 2 * WIDTH; i++) begin
      phase[i] = (k == i);
    end
  end

  // Strobes are masked while rst is asserted so the reset cycle shows idle outputs.
  assign jc_enable = jc_en_raw & ~rst;
  assign req_ready = ready_raw & {2{~rst}};
  assign done      = done_raw & {2{~rst}};
  assign busy      = (state_q != IDLE) & ~rst;
  assign count     = count_q;
  assign owner     = owner_q;

endmodule
